// File: rtl/serial_paralelo_sync.sv
// serial_paralelo_sync: comma-aligned serial-to-parallel receiver with SEARCH/ALIGN/ACTIVE lock FSM.
// Define SERIAL_PARALELO_REALIGN_EN to realign on off-boundary commas while ACTIVE.
module serial_paralelo_sync #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] COMMA      = 'hBC,
   parameter int               LOCK_COUNT = 4
)(
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             active,
   output logic             comma_det
);
   localparam int BW = $clog2(WIDTH);
   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam logic [1:0] S_SEARCH = 2'd0, S_ALIGN = 2'd1, S_ACTIVE = 2'd2;
   localparam logic [1:0] S_LOCK = (LOCK_COUNT == 1) ? S_ACTIVE : S_ALIGN;
   logic [WIDTH-2:0] r_sr;
   logic [BW-1:0]    r_bit;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_state;
   logic [WIDTH-1:0] w_nxt;
   logic [CW-1:0]    w_cnt_inc;
   logic             w_comma, w_bnd;
   assign w_nxt     = {r_sr, data_in};
   assign w_comma   = w_nxt == COMMA;
   assign w_bnd     = r_bit == BW'(WIDTH - 1);
   assign w_cnt_inc = r_cnt + 1'b1;
   assign active    = r_state == S_ACTIVE;
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         r_sr      <= '0;
         r_bit     <= '0;
         r_cnt     <= '0;
         r_state   <= S_SEARCH;
         data_out  <= '0;
         valid_out <= 1'b0;
         comma_det <= 1'b0;
      end else begin
         r_sr      <= w_nxt[WIDTH-2:0];
         r_bit     <= w_bnd ? '0 : r_bit + 1'b1;
         valid_out <= 1'b0;
         comma_det <= 1'b0;
         case (r_state)
            S_SEARCH: if (w_comma) begin
               r_bit     <= '0;
               r_cnt     <= CW'(1);
               comma_det <= 1'b1;
               r_state   <= S_LOCK;
            end
            S_ALIGN: if (w_bnd) begin
               if (w_comma) begin
                  r_cnt     <= w_cnt_inc;
                  comma_det <= 1'b1;
                  if (w_cnt_inc == CW'(LOCK_COUNT)) r_state <= S_ACTIVE;
               end else begin
                  r_cnt   <= '0;
                  r_state <= S_SEARCH;
               end
            end
            S_ACTIVE: if (w_bnd) begin
               if (w_comma) comma_det <= 1'b1;
               else begin
                  data_out  <= w_nxt;
                  valid_out <= 1'b1;
               end
            end
`ifdef SERIAL_PARALELO_REALIGN_EN
            else if (w_comma) begin
               r_bit     <= '0;
               r_cnt     <= CW'(1);
               comma_det <= 1'b1;
               r_state   <= S_LOCK;
            end
`endif
            default: r_state <= S_SEARCH;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_paralelo_sync.sv
// tb_serial_paralelo_sync: directed vectors for 8-bit and 10-bit receivers, with and without SERIAL_PARALELO_REALIGN_EN.
module tb_serial_paralelo_sync;
   logic clk = 1'b0, rst = 1'b1, d8 = 1'b1, d10 = 1'b1;
   logic [7:0] q8;
   logic [9:0] q10;
   logic v8, a8, c8, v10, a10, c10;
   int n_vec = 0, n_err = 0, nv8 = 0, ncd8 = 0, nv10 = 0, nboth = 0;

   always #5 clk = ~clk;

   serial_paralelo_sync u8 (
      .clk_32f(clk), .reset(rst), .data_in(d8),
      .data_out(q8), .valid_out(v8), .active(a8), .comma_det(c8));

   serial_paralelo_sync #(.WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(2)) u10 (
      .clk_32f(clk), .reset(rst), .data_in(d10),
      .data_out(q10), .valid_out(v10), .active(a10), .comma_det(c10));

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic sb(input bit u, input logic b);
      @(negedge clk);
      if (u) d10 = b; else d8 = b;
      @(posedge clk);
      #1;
      if (v8) nv8++;
      if (c8) ncd8++;
      if (v10) nv10++;
      if ((v8 && c8) || (v10 && c10)) nboth++;
   endtask

   task automatic sw8(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) sb(1'b0, w[i]);
   endtask

   task automatic sw10(input logic [9:0] w);
      for (int i = 9; i >= 0; i--) sb(1'b1, w[i]);
   endtask

   task automatic clr();
      nv8 = 0; ncd8 = 0; nv10 = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", 16'(q8), 16'h0);
      chk("rst_valid", 16'(v8), 16'h0);
      chk("rst_active", 16'(a8), 16'h0);
      chk("rst_comma", 16'(c8), 16'h0);
      rst = 1'b0;
      // lock with four aligned commas, then two data words
      for (int i = 0; i < 10; i++) sb(1'b0, 1'b1);
      clr();
      repeat (3) sw8(8'hBC);
      chk("t1_act_3rd", 16'(a8), 16'h0);
      sw8(8'hBC);
      chk("t1_act_4th", 16'(a8), 16'h1);
      chk("t1_comma_4th", 16'(c8), 16'h1);
      sw8(8'hA5);
      chk("t1_valid_a5", 16'(v8), 16'h1);
      chk("t1_data_a5", 16'(q8), 16'hA5);
      sw8(8'h3C);
      chk("t1_data_3c", 16'(q8), 16'h3C);
      chk("t1_nvalid", 16'(nv8), 16'd2);
      chk("t1_ncomma", 16'(ncd8), 16'd4);
      // broken comma run falls back to SEARCH
      do_reset();
      clr();
      sw8(8'hBC);
      sw8(8'hBC);
      sw8(8'hFF);
      chk("t2_act_ff", 16'(a8), 16'h0);
      chk("t2_comma_ff", 16'(c8), 16'h0);
      repeat (3) sw8(8'hBC);
      chk("t2_act_3rd", 16'(a8), 16'h0);
      sw8(8'hBC);
      chk("t2_act_4th", 16'(a8), 16'h1);
      sw8(8'h5A);
      chk("t2_data_5a", 16'(q8), 16'h5A);
      chk("t2_nvalid", 16'(nv8), 16'd1);
      chk("t2_ncomma", 16'(ncd8), 16'd6);
      // comma inside active data stream
      clr();
      sw8(8'h77);
      chk("t3_data_77", 16'(q8), 16'h77);
      sw8(8'hBC);
      chk("t3_bc_valid", 16'(v8), 16'h0);
      chk("t3_bc_comma", 16'(c8), 16'h1);
      chk("t3_bc_hold", 16'(q8), 16'h77);
      sw8(8'h12);
      chk("t3_data_12", 16'(q8), 16'h12);
      chk("t3_nvalid", 16'(nv8), 16'd2);
      // reset in the middle of a word
      sb(1'b0, 1'b1); sb(1'b0, 1'b0); sb(1'b0, 1'b1); sb(1'b0, 1'b0);
      do_reset();
      chk("t4_act", 16'(a8), 16'h0);
      chk("t4_data", 16'(q8), 16'h0);
      chk("t4_valid", 16'(v8), 16'h0);
      clr();
      sb(1'b0, 1'b0); sb(1'b0, 1'b1); sb(1'b0, 1'b0); sb(1'b0, 1'b1);
      sw8(8'hA5);
      chk("t4_no_valid", 16'(nv8), 16'd0);
      repeat (4) sw8(8'hBC);
      chk("t4_relock", 16'(a8), 16'h1);
      sw8(8'h3C);
      chk("t4_data_3c", 16'(q8), 16'h3C);
      // three stray bits then an off-boundary comma
      clr();
      repeat (3) sb(1'b0, 1'b0);
      sw8(8'hBC);
      chk("t5_early_word", 16'(q8), 16'h17);
`ifdef SERIAL_PARALELO_REALIGN_EN
      chk("t5_act_drop", 16'(a8), 16'h0);
      chk("t5_comma", 16'(c8), 16'h1);
      repeat (2) sw8(8'hBC);
      chk("t5_act_2", 16'(a8), 16'h0);
      sw8(8'hBC);
      chk("t5_relock", 16'(a8), 16'h1);
      sw8(8'hC3);
      chk("t5_data_c3", 16'(q8), 16'hC3);
      chk("t5_ncomma", 16'(ncd8), 16'd4);
`else
      chk("t5_act_kept", 16'(a8), 16'h1);
      chk("t5_comma", 16'(c8), 16'h0);
      sw8(8'hC3);
      chk("t5_misaligned", 16'(q8), 16'h98);
      chk("t5_ncomma", 16'(ncd8), 16'd0);
`endif
      chk("t5_nvalid", 16'(nv8), 16'd2);
      // 10-bit instance, two-comma lock
      clr();
      sw10(10'h17C);
      chk("t6_act_1st", 16'(a10), 16'h0);
      chk("t6_comma_1st", 16'(c10), 16'h1);
      sw10(10'h17C);
      chk("t6_act_2nd", 16'(a10), 16'h1);
      sw10(10'h2AA);
      chk("t6_valid", 16'(v10), 16'h1);
      chk("t6_data", 16'(q10), 16'h2AA);
      chk("t6_nvalid", 16'(nv10), 16'd1);
      chk("excl_valid_comma", 16'(nboth), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
